// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-step multiply/divide unit producing HI/LO writes.
//
// Ports:
//   clk, reset         - clock and asynchronous active-high reset
//   start, op, a, b    - operation request (op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//   flush              - abort the in-flight operation without writing HI/LO
//   busy               - high while an operation is in RUN or DONE
//   hi_write, lo_write - one-cycle HI/LO write enables, always asserted together
//   hi_data, lo_data   - product[63:32]/product[31:0] or remainder/quotient,
//                        zero whenever the write enables are low
module mul_div_unit #(
  parameter int unsigned STEPS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        hi_write,
  output logic        lo_write,
  output logic [31:0] hi_data,
  output logic [31:0] lo_data
);

  localparam int unsigned CW = $clog2(STEPS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;
  logic          is_div;
  logic          neg_q;
  logic          neg_r;
  logic          div_zero;
  logic [31:0]   hi_r;
  logic [31:0]   lo_r;
  logic [31:0]   b_r;

  logic          signed_op;
  logic          accept;
  logic          last_step;
  logic [31:0]   abs_a;
  logic [31:0]   abs_b;
  logic [32:0]   mul_sum;
  logic [32:0]   div_shift;
  logic [32:0]   div_diff;
  logic [63:0]   prod;

  assign signed_op = op[0];
  assign abs_a     = (signed_op && a[31]) ? -a : a;
  assign abs_b     = (signed_op && b[31]) ? -b : b;

  // A new operation may also be taken in DONE so back-to-back requests
  // start immediately after the write cycle.
  assign accept    = start && !flush && (state == IDLE || state == DONE);
  assign last_step = (count == CW'(STEPS - 1));

  // Multiply: {hi_r, lo_r} is the accumulator, lo_r starts as the multiplier
  // and is shifted out as product bits are shifted in.
  assign mul_sum   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : 33'd0);

  // Divide: hi_r is the partial remainder, lo_r starts as the dividend and
  // fills with quotient bits.
  assign div_shift = {hi_r, lo_r[31]};
  assign div_diff  = div_shift - {1'b0, b_r};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = RUN;
      RUN: begin
        if (flush) begin
          state_next = IDLE;
        end else if (last_step) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi_r     <= '0;
      lo_r     <= '0;
      b_r      <= '0;
    end else if (accept) begin
      count    <= '0;
      is_div   <= op[1];
      neg_q    <= signed_op && (a[31] ^ b[31]);
      neg_r    <= signed_op && a[31];
      div_zero <= op[1] && (b == '0);
      hi_r     <= '0;
      lo_r     <= abs_a;
      b_r      <= abs_b;
    end else if (state == RUN) begin
      count <= count + 1'b1;
      if (!is_div) begin
        {hi_r, lo_r} <= {mul_sum, lo_r[31:1]};
      end else if (!div_diff[32]) begin
        hi_r <= div_diff[31:0];
        lo_r <= {lo_r[30:0], 1'b1};
      end else begin
        hi_r <= div_shift[31:0];
        lo_r <= {lo_r[30:0], 1'b0};
      end
    end
  end

  // Outputs. With a zero divisor the remainder register ends up holding |a|,
  // so the dividend-sign fix-up restores the original a; only the quotient
  // needs forcing to all ones.
  always_comb begin
    busy     = (state != IDLE);
    hi_write = 1'b0;
    lo_write = 1'b0;
    hi_data  = '0;
    lo_data  = '0;
    prod     = {hi_r, lo_r};
    if (neg_q) begin
      prod = -prod;
    end
    if (state == DONE && !flush) begin
      hi_write = 1'b1;
      lo_write = 1'b1;
      if (!is_div) begin
        hi_data = prod[63:32];
        lo_data = prod[31:0];
      end else begin
        hi_data = neg_r ? -hi_r : hi_r;
        if (div_zero) begin
          lo_data = '1;
        end else begin
          lo_data = neg_q ? -lo_r : lo_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        hi_write;
  logic        lo_write;
  logic [31:0] hi_data;
  logic [31:0] lo_data;

  int unsigned n_checks;
  int unsigned n_fail;

  localparam logic [1:0] MULTU = 2'b00;
  localparam logic [1:0] MULT  = 2'b01;
  localparam logic [1:0] DIVU  = 2'b10;
  localparam logic [1:0] DIV   = 2'b11;

  mul_div_unit #(.STEPS(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .busy     (busy),
    .hi_write (hi_write),
    .lo_write (lo_write),
    .hi_data  (hi_data),
    .lo_data  (lo_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and follow it until busy drops. If restart_at is
  // non-zero, a competing start with other operands is pulsed at that
  // cycle and must be ignored.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int unsigned restart_at);
    int unsigned nb;
    int unsigned nhw;
    int unsigned nlw;
    int unsigned wat;
    logic [31:0] gh;
    logic [31:0] gl;
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    op = ~o; a = ~x; b = y + 32'd3;
    check({tag, " idle data"}, hi_data | lo_data, 32'h0);
    nb = 0; nhw = 0; nlw = 0; wat = 0; gh = '0; gl = '0;
    while (busy && nb < 200) begin
      nb++;
      if (hi_write) begin
        nhw++;
        gh = hi_data;
        gl = lo_data;
        wat = nb;
      end
      if (lo_write) nlw++;
      start = (nb == restart_at);
      tick();
    end
    start = 1'b0;
    check({tag, " busy cycles"}, 32'(nb), 32'd33);
    check({tag, " hi pulses"}, 32'(nhw), 32'd1);
    check({tag, " lo pulses"}, 32'(nlw), 32'd1);
    check({tag, " write cycle"}, 32'(wat), 32'd33);
    check({tag, " hi"}, gh, exp_hi);
    check({tag, " lo"}, gl, exp_lo);
  endtask

  // Counts write pulses over n cycles (used where none are expected).
  task automatic count_pulses(input int unsigned n, output int unsigned np);
    np = 0;
    for (int unsigned i = 0; i < n; i++) begin
      if (hi_write || lo_write) np++;
      tick();
    end
  endtask

  initial begin
    int unsigned np;
    int unsigned nb;
    int unsigned p1;
    int unsigned p2;
    logic [31:0] h1;
    logic [31:0] l1;
    logic [31:0] h2;
    logic [31:0] l2;
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) tick();
    check("reset busy", 32'(busy), 32'd0);
    check("reset hi_write", 32'(hi_write), 32'd0);
    check("reset lo_write", 32'(lo_write), 32'd0);
    check("reset hi_data", hi_data, 32'h0);
    check("reset lo_data", lo_data, 32'h0);
    reset = 1'b0;
    tick();

    run_op("multu max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op("multu 2^16", MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 0);
    run_op("mult -2x3", MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);
    run_op("mult min^2", MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
    run_op("mult -1x-1", MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 0);
    run_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("div 7/-2", DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0);
    run_op("divu 7/2", DIVU, 32'd7, 32'd2, 32'h0000_0001, 32'h0000_0003, 0);
    run_op("divu max/16", DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 32'h0FFF_FFFF, 0);
    run_op("div min/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
    run_op("divu 5/0", DIVU, 32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF, 0);
    run_op("div -5/0", DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);
    run_op("divu restart", DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 10);

    // flush during RUN
    op = DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    check("flush run busy before", 32'(busy), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush run busy after", 32'(busy), 32'd0);
    count_pulses(40, np);
    check("flush run pulses", 32'(np), 32'd0);

    // flush in DONE suppresses the write
    op = MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (32) tick();
    check("done hi_write", 32'(hi_write), 32'd1);
    check("done lo_data", lo_data, 32'd42);
    flush = 1'b1;
    #1;
    check("flush done hi_write", 32'(hi_write), 32'd0);
    check("flush done lo_write", 32'(lo_write), 32'd0);
    tick();
    flush = 1'b0;
    check("flush done busy", 32'(busy), 32'd0);

    // start with flush in IDLE is ignored
    op = MULTU; a = 32'd1; b = 32'd1; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush idle busy", 32'(busy), 32'd0);

    // reset mid-RUN
    op = MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    reset = 1'b1;
    #1;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset hi_write", 32'(hi_write), 32'd0);
    check("midreset data", hi_data | lo_data, 32'h0);
    tick();
    reset = 1'b0;
    count_pulses(40, np);
    check("midreset pulses", 32'(np), 32'd0);

    // back-to-back: start held high, second op accepted at E33
    op = MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    op = DIVU; a = 32'd7; b = 32'd2;
    nb = 0; np = 0; p1 = 0; p2 = 0;
    h1 = '0; l1 = '0; h2 = '0; l2 = '0;
    while (busy && nb < 300) begin
      nb++;
      if (hi_write && lo_write) begin
        np++;
        if (np == 1) begin
          p1 = nb; h1 = hi_data; l1 = lo_data;
        end else begin
          p2 = nb; h2 = hi_data; l2 = lo_data;
        end
      end
      if (nb == 34) start = 1'b0;
      tick();
    end
    start = 1'b0;
    check("b2b busy cycles", 32'(nb), 32'd66);
    check("b2b pulses", 32'(np), 32'd2);
    check("b2b first at", 32'(p1), 32'd33);
    check("b2b second at", 32'(p2), 32'd66);
    check("b2b first hi", h1, 32'hFFFF_FFFE);
    check("b2b first lo", l1, 32'h0000_0001);
    check("b2b second hi", h2, 32'h0000_0001);
    check("b2b second lo", l2, 32'h0000_0003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
